// File: rtl/serializador_8bits.sv
// Parallel-to-serial converter with load/ready handshake and a one-cycle done pulse.
// Optional even-parity bit after the data word when SERIALIZADOR_PARIDADE_EN is defined.
module serializador_8bits #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load,
  output logic             ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             done,
  output logic [3:0]       bit_count
);

  if (WIDTH < 2 || WIDTH > 15) begin : g_bad_width
    $error("serializador_8bits: WIDTH must be within 2..15");
  end

  localparam int         OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;
  localparam logic [3:0] LAST    = 4'(WIDTH - 1);

`ifdef SERIALIZADOR_PARIDADE_EN
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [3:0]       count_n;
`ifdef SERIALIZADOR_PARIDADE_EN
  // Parity is latched at capture because the shift register is consumed as it shifts.
  logic             par, par_n;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_count <= '0;
`ifdef SERIALIZADOR_PARIDADE_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_count <= count_n;
`ifdef SERIALIZADOR_PARIDADE_EN
      par       <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    count_n = bit_count;
`ifdef SERIALIZADOR_PARIDADE_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        if (load) begin
          shreg_n = d_in;
          count_n = '0;
          state_n = SHIFT;
`ifdef SERIALIZADOR_PARIDADE_EN
          par_n   = ^d_in;
`endif
        end
      end
      SHIFT: begin
        shreg_n = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
        if (bit_count == LAST) begin
`ifdef SERIALIZADOR_PARIDADE_EN
          state_n = PARITY;
          count_n = 4'(WIDTH);
`else
          state_n = DONE;
          count_n = '0;
`endif
        end else begin
          count_n = bit_count + 4'd1;
        end
      end
`ifdef SERIALIZADOR_PARIDADE_EN
      PARITY: begin
        state_n = DONE;
        count_n = '0;
      end
`endif
      DONE: begin
        state_n = IDLE;
        count_n = '0;
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  always_comb begin
    ready      = (state == IDLE);
    done       = (state == DONE);
    bit_valid  = (state == SHIFT);
    serial_out = (state == SHIFT) ? shreg[OUT_IDX] : 1'b0;
`ifdef SERIALIZADOR_PARIDADE_EN
    if (state == PARITY) begin
      bit_valid  = 1'b1;
      serial_out = par;
    end
`endif
  end

endmodule
